// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle core data-memory accesses into strobe/ack
// bus transactions, stalling the core until each one completes. Misaligned
// accesses and bus timeouts are recorded in sticky error registers.
module dmem_bridge #(
  parameter int unsigned  TIMEOUT   = 255,
  parameter logic [31:0]  ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_ren,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_dout,
  output logic [31:0] core_din,
  output logic        core_stall,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Last BUSY cycle before the transaction is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  logic [1:0]  state_r;
  logic [15:0] cnt_r;
  logic        req_s;
  logic        mis_s;
  logic        mis_err_s;
  logic        to_err_s;

  // Word accesses only: any set low address bit is a misalignment.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

  // Request decode, error triggers and the core stall.
  always_comb begin
    req_s      = core_ren | core_wen;
    mis_s      = req_s & addr_misaligned(core_addr[1:0]);
    mis_err_s  = (state_r == ST_IDLE) & mis_s;
    to_err_s   = (state_r == ST_BUSY) & ~bus_ack & (cnt_r == CNT_LAST);
    core_stall = ((state_r == ST_IDLE) & req_s & ~mis_s) | (state_r == ST_BUSY);
  end

  // Transaction FSM, bus request registers, wait counter and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      core_din  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && !mis_s) begin
            // Write wins when both request lines are high.
            bus_stb   <= 1'b1;
            bus_we    <= core_wen;
            bus_addr  <= core_addr;
            bus_wdata <= core_dout;
            cnt_r     <= 16'd0;
            state_r   <= ST_BUSY;
          end else if (mis_s && !core_wen) begin
            core_din <= ERR_RDATA;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            // An ack on the final wait cycle still counts as success.
            bus_stb <= 1'b0;
            if (!bus_we) begin
              core_din <= bus_rdata;
            end
            state_r <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            bus_stb <= 1'b0;
            if (!bus_we) begin
              core_din <= ERR_RDATA;
            end
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          // Core retires the access this cycle; its still-present request is ignored.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          bus_stb <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error registers; a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_flag <= 1'b0;
      err_code <= 2'b00;
      err_addr <= 32'd0;
    end else if (mis_err_s) begin
      err_flag <= 1'b1;
      err_code <= ERR_MISALIGN;
      err_addr <= core_addr;
    end else if (to_err_s) begin
      err_flag <= 1'b1;
      err_code <= ERR_TIMEOUT;
      err_addr <= bus_addr;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_code <= 2'b00;
      err_addr <= 32'd0;
    end else begin
      err_flag <= err_flag;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus pushes expected bus requests and
// core responses into queues, a negedge monitor pops and compares them.
module tb_dmem_bridge;

  localparam int unsigned TO      = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        core_ren;
  logic        core_wen;
  logic [31:0] core_addr;
  logic [31:0] core_dout;
  logic [31:0] core_din;
  logic        core_stall;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        err_clr;
  logic        err_flag;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
    int          gap;
  } bus_exp_t;

  typedef struct {
    logic [31:0] din;
    int          stalls;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  dmem_bridge #(.TIMEOUT(TO), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .rst(rst),
    .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr),
    .core_dout(core_dout), .core_din(core_din), .core_stall(core_stall),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .err_clr(err_clr), .err_flag(err_flag), .err_code(err_code),
    .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor state
  bit       in_txn     = 1'b0;
  bus_exp_t cur;
  int       stb_len    = 0;
  int       low_cnt    = 0;
  int       stall_cnt  = 0;
  bit       prev_stall = 1'b0;
  resp_exp_t r;

  // Monitor: compare bus requests and completed core responses against the queues.
  always @(negedge clk) begin
    if (bus_stb === 1'b1) begin
      if (!in_txn) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_stb", {31'd0, bus_stb}, 32'd0);
        end else begin
          cur     = bus_q.pop_front();
          in_txn  = 1'b1;
          stb_len = 0;
          if (cur.gap >= 0) chk("stb_gap", low_cnt, cur.gap);
        end
      end
      if (in_txn) begin
        stb_len++;
        chk("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
        chk("bus_addr", bus_addr, cur.addr);
        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
      end
      low_cnt = 0;
    end else begin
      if (in_txn) begin
        chk("stb_len", stb_len, cur.len);
        in_txn = 1'b0;
      end
      low_cnt++;
    end

    if (core_stall === 1'b1) begin
      stall_cnt++;
    end else if (prev_stall) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        r = resp_q.pop_front();
        chk("core_din", core_din, r.din);
        chk("stall_cycles", stall_cnt, r.stalls);
      end
      stall_cnt = 0;
    end
    prev_stall = (core_stall === 1'b1);
  end

  // One core access; caller is at posedge+1 and has pushed expectations.
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_cycle,
                        input logic [31:0] rdata);
    int k;
    bit done;
    core_ren  = ren;
    core_wen  = wen;
    core_addr = addr;
    core_dout = wdata;
    bus_rdata = rdata;
    bus_ack   = 1'b0;
    k         = 0;
    done      = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      k++;
      if (core_stall !== 1'b1) begin
        done = 1'b1;
      end else if (k > 40) begin
        chk("access_bound", k, 40);
        done = 1'b1;
      end else if (k == ack_cycle) begin
        bus_ack = 1'b1;
      end
    end
    @(posedge clk); #1;
    core_ren = 1'b0;
    core_wen = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; core_ren = 1'b0; core_wen = 1'b0; core_addr = 32'd0;
    core_dout = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", {31'd0, bus_stb}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_din", core_din, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_flag", {31'd0, err_flag}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_eaddr", err_addr, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Read, ack on first BUSY cycle
    bus_q.push_back('{1'b0, 32'h0000_0010, 32'h0, 1, -1});
    resp_q.push_back('{32'h1234_5678, 2});
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_5678);

    // Write, ack after 4 BUSY cycles; read data unchanged
    bus_q.push_back('{1'b1, 32'h0000_0020, 32'hCAFE_BABE, 4, -1});
    resp_q.push_back('{32'h1234_5678, 5});
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_BABE, 4, 32'h5555_5555);

    // Misaligned read: no stall, no bus access, error recorded
    core_ren = 1'b1; core_addr = 32'h0000_0013;
    #1;
    chk("mis_stall", {31'd0, core_stall}, 32'd0);
    @(posedge clk); #1;
    core_ren = 1'b0;
    chk("mis_din", core_din, ERR_VAL);
    chk("mis_flag", {31'd0, err_flag}, 32'd1);
    chk("mis_code", {30'd0, err_code}, 32'd1);
    chk("mis_eaddr", err_addr, 32'h0000_0013);
    clear_err();
    chk("clr_flag", {31'd0, err_flag}, 32'd0);
    chk("clr_code", {30'd0, err_code}, 32'd0);
    chk("clr_eaddr", err_addr, 32'd0);

    // Misaligned write together with clear: error wins, read data untouched
    core_wen = 1'b1; core_addr = 32'h0000_0022; core_dout = 32'h0BAD_0BAD; err_clr = 1'b1;
    @(posedge clk); #1;
    core_wen = 1'b0; err_clr = 1'b0;
    chk("setwin_flag", {31'd0, err_flag}, 32'd1);
    chk("setwin_code", {30'd0, err_code}, 32'd1);
    chk("setwin_eaddr", err_addr, 32'h0000_0022);
    chk("setwin_din", core_din, ERR_VAL);
    clear_err();

    // Timeout: no ack, strobe held TO cycles
    bus_q.push_back('{1'b0, 32'h0000_0040, 32'h0, TO, -1});
    resp_q.push_back('{ERR_VAL, TO + 1});
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0);
    chk("to_flag", {31'd0, err_flag}, 32'd1);
    chk("to_code", {30'd0, err_code}, 32'd2);
    chk("to_eaddr", err_addr, 32'h0000_0040);
    clear_err();

    // Ack on the last allowed cycle: success, no error
    bus_q.push_back('{1'b0, 32'h0000_0044, 32'h0, TO, -1});
    resp_q.push_back('{32'hA5A5_0F0F, TO + 1});
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, TO, 32'hA5A5_0F0F);
    chk("late_ack_flag", {31'd0, err_flag}, 32'd0);

    // Both request lines high: treated as write
    bus_q.push_back('{1'b1, 32'h0000_0050, 32'h1122_3344, 2, -1});
    resp_q.push_back('{32'hA5A5_0F0F, 3});
    access(1'b1, 1'b1, 32'h0000_0050, 32'h1122_3344, 2, 32'h7777_7777);

    // Back-to-back reads: strobe low through DONE and the following IDLE
    bus_q.push_back('{1'b0, 32'h0000_0060, 32'h0, 1, -1});
    resp_q.push_back('{32'h600D_0001, 2});
    bus_q.push_back('{1'b0, 32'h0000_0064, 32'h0, 1, 2});
    resp_q.push_back('{32'h600D_0002, 2});
    access(1'b1, 1'b0, 32'h0000_0060, 32'h0, 1, 32'h600D_0001);
    access(1'b1, 1'b0, 32'h0000_0064, 32'h0, 1, 32'h600D_0002);

    // Reset in the third BUSY cycle, then a stray ack
    bus_q.push_back('{1'b0, 32'h0000_0070, 32'h0, 3, -1});
    resp_q.push_back('{32'h0, 4});
    core_ren = 1'b1; core_addr = 32'h0000_0070; bus_rdata = 32'hFFFF_0000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0; core_ren = 1'b0;
    @(posedge clk); #1;
    chk("rstb_stb", {31'd0, bus_stb}, 32'd0);
    chk("rstb_stall", {31'd0, core_stall}, 32'd0);
    rst = 1'b1; bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("stray_din", core_din, 32'd0);
    chk("stray_stb", {31'd0, bus_stb}, 32'd0);
    chk("stray_flag", {31'd0, err_flag}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("resp_q_empty", resp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the MIPS core's data-memory ports (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Converts each single-cycle core access into a strobe/ack transaction on a multi-cycle data-memory bus.
- Stalls the core until the transaction completes.
- Flags misaligned accesses and bus timeouts in sticky error state, readable by debug logic.

Parameters:
TIMEOUT, 255, max BUSY cycles waiting for bus_ack before abort (1..65535)
ERR_RDATA, 32'h0000_0000, data returned to core on aborted/misaligned read

Ports:
clk  input  1  main clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets)
core_ren  input  1  core read request (from core mem_ren)
core_wen  input  1  core write request (from core mem_wen)
core_addr  input  32  byte address (from core mem_addr)
core_dout  input  32  write data (from core mem_dout)
core_din  output  32  read data to core (core mem_din), registered
core_stall  output  1  high: core must hold PC and pipeline, keep request stable
bus_stb  output  1  bus request strobe, registered
bus_we  output  1  bus write enable, valid while bus_stb
bus_addr  output  32  bus word address (byte address, [1:0]=0), valid while bus_stb
bus_wdata  output  32  bus write data, valid while bus_stb&bus_we
bus_rdata  input  32  bus read data, sampled when bus_ack
bus_ack  input  1  bus completion, one cycle pulse
err_clr  input  1  clears err_flag/err_code/err_addr
err_flag  output  1  sticky error indicator
err_code  output  2  01 misaligned, 10 timeout; last error wins
err_addr  output  32  core_addr of last erroring access

Behaviour:
- Reset (rst==0 at edge): state IDLE; core_din, bus_stb, bus_we, bus_addr, bus_wdata, err_flag, err_code, err_addr, timeout counter all 0. core_stall=0 while in IDLE with no request. Reset mid-transaction drops bus_stb next edge; pending ack ignored.
- req = core_ren|core_wen. If both high, treat as write (wen priority).
- misaligned = req & (core_addr[1:0]!=0).
- core_stall (combinational) = (IDLE & req & ~misaligned) | BUSY. Low in DONE.
- States:
  - IDLE:
    - aligned req: latch bus_addr=core_addr, bus_we=core_wen, bus_wdata=core_dout; bus_stb=1 at edge; counter=0; next BUSY.
    - misaligned req: no bus access, no stall; core_din<=ERR_RDATA if read; err_flag<=1, err_code<=01, err_addr<=core_addr; stay IDLE.
  - BUSY: bus_stb held high, outputs stable.
    - bus_ack: bus_stb<=0; if read, core_din<=bus_rdata; next DONE.
    - counter==TIMEOUT-1 and no ack: bus_stb<=0; if read, core_din<=ERR_RDATA; err_flag<=1, err_code<=10, err_addr<=bus_addr; next DONE.
    - else counter++.
    - Ack in same cycle as timeout: ack wins, no error.
  - DONE: stall low one cycle so core retires the access; core request this cycle is the same access and is ignored; next IDLE.
- Latency: ack on first BUSY cycle gives 3 cycles total (IDLE, BUSY, DONE), 2 stall cycles. Each extra ack-wait cycle adds 1.
- core_din holds the last read value until the next read completes; writes do not change it.
- bus_ack outside BUSY ignored.
- err_clr: clears error regs at edge. A simultaneous new error takes priority over clear (set wins).
- Counter width 16 bits.

Test Plan:
- Read 0x0000_0010, bus_ack 1 cycle after stb, bus_rdata=0x1234_5678 -> stall high 2 cycles; bus_addr=0x10, bus_we=0; core_din=0x1234_5678 in DONE; stb low after ack.
- Write 0x0000_0020 data 0xCAFEBABE, ack after 4 BUSY cycles -> bus_we=1, bus_wdata=0xCAFEBABE stable for 4 cycles; stall 5 cycles; core_din unchanged.
- Read 0x0000_0013 -> no bus_stb, stall 0; core_din=ERR_RDATA; err_flag=1, err_code=01, err_addr=0x13. Then err_clr -> all error regs 0.
- TIMEOUT=8, read with no ack -> bus_stb high exactly 8 cycles then low; DONE; core_din=0; err_code=10. Variant: ack on 8th cycle -> no error, data returned.
- ren and wen both high -> bus_we=1 (write). Back-to-back reads -> second stb starts the cycle after DONE.
- rst low during BUSY -> next edge: bus_stb=0, stall=0, IDLE. Late bus_ack ignored, core_din=0.
